gray_count_gen: RTL and testbench

- Synchronous N-bit Gray-code sequence generator.
- Sits directly upstream of the Gray-to-binary converter and drives its Gray input bus one code per enabled clock.
- Supports up/down counting, parallel load of a binary start value, wrap or one-shot (stop-at-terminal) modes, and a terminal-count strobe.
- Used as the stimulus source for the code-converter lab chain and as a glitch-safe position counter.

---
 rtl/gray_count_gen.sv | 77 +++++++
 tb/tb_gray_count_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gray_count_gen.sv
// Gray-code sequence generator: up/down, parallel load, wrap or one-shot, terminal strobe.
// All outputs registered, one-cycle latency from en/load; no flow control (en gates each step).
module gray_count_gen #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_bin,
  input  logic         one_shot,
  output logic [N-1:0] g,
  output logic         tc,
  output logic         done,
  output logic         step_err
);

  typedef enum logic {RUN, DONE} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  logic [N-1:0] b;
  logic [N-1:0] b_nxt;
  logic [N-1:0] g_q;
  logic [N-1:0] g_diff;
  logic         seeded_q;
  logic         at_terminal;
  logic         multi_bit;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] x);
    return x ^ (x >> 1);
  endfunction

  always_comb begin
    b_nxt       = up ? (b + ONE) : (b - ONE);
    at_terminal = up ? (b_nxt == {N{1'b1}}) : (b_nxt == {N{1'b0}});
    g_diff      = g ^ g_q;
    multi_bit   = (g_diff != {N{1'b0}}) && ((g_diff & (g_diff - ONE)) != {N{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      b        <= '0;
      g        <= '0;
      g_q      <= '0;
      tc       <= 1'b0;
      step_err <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      g_q      <= g;
      seeded_q <= load;
      tc       <= 1'b0;
      // The cycle right after a load compares against a freshly seeded code, so skip it.
      if (!seeded_q && multi_bit)
        step_err <= 1'b1;
      if (load) begin
        b     <= load_bin;
        g     <= to_gray(load_bin);
        state <= RUN;
      end else if (en && state == RUN) begin
        b <= b_nxt;
        g <= to_gray(b_nxt);
        if (at_terminal) begin
          tc <= 1'b1;
          if (one_shot)
            state <= DONE;
        end
      end
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_gray_count_gen.sv
// Directed bench for gray_count_gen (N=3) with hand-computed Gray sequences.
module tb_gray_count_gen;

  logic       clk = 1'b0;
  logic       rst, en, up, load, one_shot;
  logic [2:0] load_bin;
  logic [2:0] g;
  logic       tc, done, step_err;

  int checks = 0;
  int errors = 0;

  gray_count_gen #(.N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .one_shot (one_shot),
    .g        (g),
    .tc       (tc),
    .done     (done),
    .step_err (step_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned eg, input int unsigned etc,
                           input int unsigned edone);
    check({tag, ".g"}, g, eg);
    check({tag, ".tc"}, tc, etc);
    check({tag, ".done"}, done, edone);
    check({tag, ".step_err"}, step_err, 0);
  endtask

  int up_seq [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
  int os_g   [5] = '{3'b101, 3'b100, 3'b100, 3'b100, 3'b100};
  int os_tc  [5] = '{0, 1, 0, 0, 0};
  int os_dn  [5] = '{0, 1, 1, 1, 1};

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; one_shot = 1'b0; load_bin = 3'b000;
    #2;
    step();
    check_out("reset", 0, 0, 0);

    // Up count with wrap
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      check_out($sformatf("up%0d", i), up_seq[i], (i == 6) ? 1 : 0, 0);
    end

    // Down wrap
    en = 1'b0; load = 1'b1; load_bin = 3'b001;
    step();
    check_out("dn_load", 3'b001, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); check_out("dn0", 3'b000, 1, 0);
    step(); check_out("dn1", 3'b100, 0, 0);
    step(); check_out("dn2", 3'b101, 0, 0);

    // One-shot stop at terminal
    en = 1'b0; load = 1'b1; load_bin = 3'b101;
    step();
    check_out("os_load", 3'b111, 0, 0);
    load = 1'b0; one_shot = 1'b1; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("os%0d", i), os_g[i], os_tc[i], os_dn[i]);
    end
    up = 1'b0; one_shot = 1'b0;
    step();
    check_out("os_flip", 3'b100, 0, 1);

    // Load exits DONE
    en = 1'b0; load = 1'b1; load_bin = 3'b010;
    step();
    check_out("exit_load", 3'b011, 0, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check_out("exit_step", 3'b010, 0, 0);

    // Priority: rst beats load and en, load beats en
    rst = 1'b1; load = 1'b1; load_bin = 3'b110; en = 1'b1;
    step();
    check_out("pri_rst", 3'b000, 0, 0);
    rst = 1'b0;
    step();
    check_out("pri_load", 3'b101, 0, 0);

    // Hold and direction flip from g=000
    rst = 1'b1; load = 1'b0; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    step(); check_out("hf0", 3'b001, 0, 0);
    en = 1'b0;
    step(); check_out("hf1", 3'b001, 0, 0);
    en = 1'b1; up = 1'b0;
    step(); check_out("hf2", 3'b000, 1, 0);
    en = 1'b0;
    step(); check_out("hf_end", 3'b000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
